// File: rtl/class_arbiter.sv
// Moves one word per grant from four class FIFOs into the shared output FIFO.
// Each grant is an IDLE -> ISSUE -> COOL sequence, so at most one word moves every 3 cycles.
module class_arbiter #(
  parameter int DATA_WIDTH = 12,
  parameter int ARB_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            state,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  input  logic                  empty_0,
  input  logic                  empty_1,
  input  logic                  empty_2,
  input  logic                  empty_3,
  input  logic                  almost_full,
  output logic                  pop_0,
  output logic                  pop_1,
  output logic                  pop_2,
  output logic                  pop_3,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            grant
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_COOL  = 2'd2;

  localparam logic [3:0] ST_INIT = 4'b0001;

  logic [1:0]            fsm;
  logic [3:0]            pop_r;
  logic [3:0]            avail;
  logic [DATA_WIDTH-1:0] din [4];
  logic                  active;
  logic                  go;
  logic [1:0]            win;
  logic                  found;
  logic [1:0]            idx;

  assign avail  = ~{empty_3, empty_2, empty_1, empty_0};
  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign din[2] = data_in_2;
  assign din[3] = data_in_3;
  assign active = (state == 4'b0100) || (state == 4'b1000);
  assign go     = active && !almost_full && (|avail);

  // Round-robin scans grant+1 .. grant+4 (wrapping), so the last winner goes last.
  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    if (ARB_MODE == 1) begin
      for (int i = 3; i >= 0; i--) begin
        if (avail[i]) win = 2'(i);
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = grant + 2'(k);
        if (!found && avail[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state == ST_INIT) begin
      fsm      <= S_IDLE;
      pop_r    <= 4'd0;
      push     <= 1'b0;
      data_out <= '0;
      grant    <= 2'd3;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (go) begin
            fsm      <= S_ISSUE;
            pop_r    <= 4'b0001 << win;
            push     <= 1'b1;
            data_out <= din[win];
            grant    <= win;
          end
        end
        S_ISSUE: begin
          fsm   <= S_COOL;
          pop_r <= 4'd0;
          push  <= 1'b0;
        end
        default: begin
          fsm   <= S_IDLE;
          pop_r <= 4'd0;
          push  <= 1'b0;
        end
      endcase
    end
  end

  assign pop_0 = pop_r[0];
  assign pop_1 = pop_r[1];
  assign pop_2 = pop_r[2];
  assign pop_3 = pop_r[3];

endmodule

// File: tb/tb_class_arbiter.sv
// Directed bench: a round-robin and a strict-priority instance, each fed by simple counting FIFO models.
module tb_class_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  state;
  logic        almost_full;
  logic [11:0] hd [4];

  int fill_rr [4];
  int popd_rr [4];
  int fill_sp [4];
  int popd_sp [4];

  logic [3:0]  empty_rr, empty_sp, pop_rr, pop_sp;
  logic        push_rr, push_sp;
  logic [11:0] dout_rr, dout_sp;
  logic [1:0]  grant_rr, grant_sp;

  int checks = 0;
  int errors = 0;
  int inv_bad = 0;
  int gq_rr[$];
  int gq_sp[$];
  int dq_rr[$];

  always #5 clk = ~clk;

  for (genvar c = 0; c < 4; c++) begin : g_empty
    assign empty_rr[c] = (fill_rr[c] == popd_rr[c]);
    assign empty_sp[c] = (fill_sp[c] == popd_sp[c]);
  end

  class_arbiter #(.DATA_WIDTH(12), .ARB_MODE(0)) u_rr (
    .clk(clk), .reset(reset), .state(state),
    .data_in_0(hd[0]), .data_in_1(hd[1]), .data_in_2(hd[2]), .data_in_3(hd[3]),
    .empty_0(empty_rr[0]), .empty_1(empty_rr[1]), .empty_2(empty_rr[2]), .empty_3(empty_rr[3]),
    .almost_full(almost_full),
    .pop_0(pop_rr[0]), .pop_1(pop_rr[1]), .pop_2(pop_rr[2]), .pop_3(pop_rr[3]),
    .push(push_rr), .data_out(dout_rr), .grant(grant_rr)
  );

  class_arbiter #(.DATA_WIDTH(12), .ARB_MODE(1)) u_sp (
    .clk(clk), .reset(reset), .state(state),
    .data_in_0(hd[0]), .data_in_1(hd[1]), .data_in_2(hd[2]), .data_in_3(hd[3]),
    .empty_0(empty_sp[0]), .empty_1(empty_sp[1]), .empty_2(empty_sp[2]), .empty_3(empty_sp[3]),
    .almost_full(almost_full),
    .pop_0(pop_sp[0]), .pop_1(pop_sp[1]), .pop_2(pop_sp[2]), .pop_3(pop_sp[3]),
    .push(push_sp), .data_out(dout_sp), .grant(grant_sp)
  );

  // FIFO models: a pop strobe seen at an edge removes the head word.
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (pop_rr[c]) popd_rr[c] <= popd_rr[c] + 1;
      if (pop_sp[c]) popd_sp[c] <= popd_sp[c] + 1;
    end
  end

  always @(negedge clk) begin
    if (push_rr) begin
      gq_rr.push_back(int'(grant_rr));
      dq_rr.push_back(int'(dout_rr));
    end
    if (push_sp) gq_sp.push_back(int'(grant_sp));
    if (push_rr != (|pop_rr) || !$onehot0(pop_rr) || (pop_rr & empty_rr) != 4'd0) inv_bad++;
    if (push_sp != (|pop_sp) || !$onehot0(pop_sp) || (pop_sp & empty_sp) != 4'd0) inv_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, base_sp, rem;
    logic [11:0] w;
    for (int c = 0; c < 4; c++) begin
      fill_rr[c] = 0; fill_sp[c] = 0; popd_rr[c] = 0; popd_sp[c] = 0;
      w = {c[1:0], 10'h1A5};
      hd[c] = w;
    end
    reset = 1'b1; state = 4'b0001; almost_full = 1'b0;
    tick(2);
    reset = 1'b0;
    check("rst_push", push_rr, 0);
    check("rst_pop", pop_rr, 0);
    check("rst_dout", dout_rr, 0);
    check("rst_grant", grant_rr, 3);

    // Single class 2 with three words: one transfer every 3 cycles, then silence.
    fill_rr[2] = popd_rr[2] + 3;
    state = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("t1_push", push_rr, (i < 9 && i % 3 == 0) ? 1 : 0);
      check("t1_pop2", pop_rr[2], (i < 9 && i % 3 == 0) ? 1 : 0);
      if (i == 0) begin
        check("t1_dout", dout_rr, 12'h9A5);
        check("t1_grant", grant_rr, 2);
      end
      if (i == 1) check("t1_dout_hold", dout_rr, 12'h9A5);
    end

    // Reset through the INIT state, then all classes loaded on both instances.
    state = 4'b0001;
    tick(1);
    check("init_grant", grant_rr, 3);
    check("init_push", push_rr, 0);
    base = gq_rr.size();
    base_sp = gq_sp.size();
    for (int c = 0; c < 4; c++) fill_rr[c] = popd_rr[c] + 3;
    fill_sp[1] = popd_sp[1] + 2;
    fill_sp[3] = popd_sp[3] + 2;
    state = 4'b1000;
    tick(45);
    check("rr_count", gq_rr.size() - base, 12);
    for (int i = 0; i < 12; i++) begin
      if (base + i < gq_rr.size()) begin
        check("rr_seq", gq_rr[base + i], i % 4);
        check("rr_data", dq_rr[base + i], {20'd0, 2'(i % 4), 10'h1A5});
      end
    end
    check("sp_count", gq_sp.size() - base_sp, 4);
    for (int i = 0; i < 4; i++) begin
      if (base_sp + i < gq_sp.size())
        check("sp_seq", gq_sp[base_sp + i], (i < 2) ? 1 : 3);
    end

    // almost_full holds off the grant; release starts the transfer one cycle later.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    almost_full = 1'b1;
    fill_rr[0] = popd_rr[0] + 1;
    state = 4'b0100;
    base = gq_rr.size();
    tick(5);
    check("af_no_push", gq_rr.size() - base, 0);
    check("af_no_pop", pop_rr, 0);
    almost_full = 1'b0;
    tick(1);
    check("af_rel_push", push_rr, 1);
    check("af_rel_pop0", pop_rr[0], 1);
    tick(3);

    // Leaving ACTIVE during ISSUE: the word in flight completes exactly once.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    fill_rr[0] = popd_rr[0] + 3;
    base = gq_rr.size();
    tick(1);
    check("idle_issue_push", push_rr, 1);
    state = 4'b0010;
    tick(12);
    check("idle_one_push", gq_rr.size() - base, 1);
    rem = fill_rr[0] - popd_rr[0];
    check("idle_remaining", rem, 2);

    // Reset during ISSUE restarts the round-robin search at class 0.
    fill_rr[1] = popd_rr[1] + 1;
    fill_rr[2] = popd_rr[2] + 1;
    state = 4'b0100;
    tick(1);
    check("rst_mid_push", push_rr, 1);
    check("rst_mid_grant", grant_rr, 1);
    reset = 1'b1;
    tick(1);
    check("rst_mid_push0", push_rr, 0);
    check("rst_mid_pop0", pop_rr, 0);
    check("rst_mid_grant3", grant_rr, 3);
    check("rst_mid_dout0", dout_rr, 0);
    rem = fill_rr[1] - popd_rr[1];
    check("rst_mid_popped", rem, 0);
    reset = 1'b0;
    tick(1);
    check("rst_after_push", push_rr, 1);
    check("rst_after_grant", grant_rr, 0);
    check("rst_after_pop0", pop_rr[0], 1);
    tick(4);

    check("invariants", inv_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/class_arbiter.md
Name: class_arbiter

Overview:
- Transmit-side counterpart of the class referee in the transaction layer.
- Drains the four per-class FIFOs (class 0..3) into one shared output FIFO, moving one word per grant.
- Uses round-robin or strict-priority arbitration and is gated by the transaction-layer state bus.
- All source and destination FIFOs are first-word-fall-through: the head word is valid on the data bus whenever empty is low.

Parameters:
- DATA_WIDTH, 12, word width; bits [DATA_WIDTH-1:DATA_WIDTH-2] carry the class.
- ARB_MODE, 0, 0 = round-robin, 1 = strict priority with class 0 highest.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- state  input  4  transaction-layer state: 4'b0001 INIT, 4'b0010 IDLE, 4'b0100 ACTIVE, 4'b1000 ACTIVE.
- data_in_0..data_in_3  input  DATA_WIDTH each  head word of class FIFO 0..3.
- empty_0..empty_3  input  1 each  class FIFO 0..3 empty.
- almost_full  input  1  output FIFO almost full.
- pop_0..pop_3  output  1 each  pop strobe to class FIFO 0..3, registered.
- push  output  1  push strobe to output FIFO, registered.
- data_out  output  DATA_WIDTH  word to output FIFO, registered; valid when push = 1.
- grant  output  2  index of the last granted class, registered.

Behaviour:
- Reset values: reset = 1, or state = 4'b0001 while reset = 0, clears the following at the next edge, with no exceptions:
  - all pop_x = 0, push = 0, data_out = 0, grant = 2'd3 (so the first round-robin search starts at class 0);
  - FSM goes to IDLE.
- FSM has three states: IDLE, ISSUE, COOL.
- IDLE:
  - Stays in IDLE if state is not ACTIVE, if almost_full = 1, or if all empty_x = 1.
  - Otherwise selects winner w and moves to ISSUE. At that same edge it registers pop_w = 1, push = 1, data_out = data_in_w, grant = w.
- ISSUE:
  - Lasts exactly one cycle, so every strobe is a one-cycle pulse.
  - At the next edge all pop_x = 0 and push = 0; data_out and grant hold their values; FSM moves to COOL.
- COOL:
  - Lasts one cycle so the FIFO flags can update after the pop and push.
  - Moves to IDLE. No strobes are asserted.
- Throughput: at most one word per 3 cycles.
- Latency: pop and push assert 1 cycle after the eligibility condition is sampled in IDLE.
- Winner selection:
  - Round-robin: scan classes grant+1, grant+2, grant+3, grant (mod 4); the first with empty_x = 0 wins.
  - Strict priority: lowest index with empty_x = 0 wins.
- Invariants:
  - Exactly one pop_x is high whenever push is high, and only then.
  - pop_x is never asserted while empty_x = 1.
  - push is never asserted while almost_full = 1 was sampled in IDLE.
- State leaving ACTIVE: if state leaves ACTIVE during ISSUE or COOL, the sequence still completes, so the word is never lost or duplicated. The FSM then waits in IDLE.
- almost_full rising during ISSUE or COOL: the in-flight word completes; no new grant is made until almost_full = 0.
- Reset mid-operation: all strobes drop at the next edge. A word popped in that same cycle is also pushed in that same cycle, so no partial transfer exists.
- Class field: data_out passes data_in_w unmodified. The class bits are not checked against w.

Test Plan:
- Reset, then state = 4'b0100, only FIFO 2 non-empty holding 12'h9A5 → pop_2 = 1 and push = 1 for one cycle with data_out = 12'h9A5 and grant = 2; nothing else for 2 cycles; repeats every 3 cycles until empty_2 = 1.
- ARB_MODE = 0, all four FIFOs non-empty with 3 words each → grant sequence 0,1,2,3,0,1,2,3,0,1,2,3; push count 12.
- ARB_MODE = 1, FIFOs 1 and 3 non-empty with 2 words each → grant 1,1,3,3.
- almost_full = 1 with FIFO 0 non-empty → no pop_0 and no push; release almost_full → transfer starts 1 cycle later.
- state set to 4'b0010 mid-ISSUE → that transfer completes, then no further pops while not ACTIVE.
- reset = 1 asserted during ISSUE → all strobes 0 at the next edge, grant = 3, FSM IDLE; the first grant after reset is class 0.
